// File: rtl/mandelbrot_pkg.sv
// Shared definitions for the Mandelbrot iteration sequencer: FSM state
// encoding, default widths and the fixed-point format of c and z.
package mandelbrot_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_ITER_W = 8;

  // c and z are signed 2.(WIDTH-2): two integer bits, the rest fractional.
  localparam int FRAC_BITS = DEF_WIDTH - 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : mandelbrot_pkg

// File: rtl/mandelbrot_iter_ctrl.sv
// Per-pixel iteration sequencer for an external single-step Mandelbrot
// datapath. A pixel (c, limit) is accepted in IDLE, the step unit is fed the
// registered z and c once per cycle in ITER, and the iteration count is held
// in DONE until the consumer takes it.
//
// Build option: define MANDEL_FIXED_POINT_EXIT_EN to end a pixel early when
// the step unit returns z unchanged (reported as having reached the limit).
module mandelbrot_iter_ctrl
  import mandelbrot_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ITER_W = DEF_ITER_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_valid,
  output logic                     start_ready,
  input  logic signed [WIDTH-1:0]  in_cr,
  input  logic signed [WIDTH-1:0]  in_ci,
  input  logic        [ITER_W-1:0] in_max_iter,
  output logic signed [WIDTH-1:0]  step_cr,
  output logic signed [WIDTH-1:0]  step_ci,
  output logic signed [WIDTH-1:0]  step_zr,
  output logic signed [WIDTH-1:0]  step_zi,
  input  logic signed [WIDTH-1:0]  step_zr_next,
  input  logic signed [WIDTH-1:0]  step_zi_next,
  input  logic                     step_size,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic        [ITER_W-1:0] result_iter,
  output logic                     result_escaped,
  output logic                     busy
);

  state_t                  state_q, state_d;
  logic signed [WIDTH-1:0] cr_q, cr_d;
  logic signed [WIDTH-1:0] ci_q, ci_d;
  logic signed [WIDTH-1:0] zr_q, zr_d;
  logic signed [WIDTH-1:0] zi_q, zi_d;
  logic [ITER_W-1:0]       cnt_q, cnt_d;
  logic [ITER_W-1:0]       max_q, max_d;
  logic [ITER_W-1:0]       res_iter_q, res_iter_d;
  logic                    res_esc_q, res_esc_d;
  logic                    fixed_pt;

`ifdef MANDEL_FIXED_POINT_EXIT_EN
  // The orbit has settled: another step would return the same z forever.
  assign fixed_pt = (step_zr_next == zr_q) && (step_zi_next == zi_q);
`else
  assign fixed_pt = 1'b0;
`endif

  // Next-state logic for the FSM, operand registers and iteration counter.
  always_comb begin
    // NOTE: every _d starts as its _q so that no path through the case
    // leaves a signal unassigned, which would infer a latch.
    state_d    = state_q;
    cr_d       = cr_q;
    ci_d       = ci_q;
    zr_d       = zr_q;
    zi_d       = zi_q;
    cnt_d      = cnt_q;
    max_d      = max_q;
    res_iter_d = res_iter_q;
    res_esc_d  = res_esc_q;

    case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          cr_d    = in_cr;
          ci_d    = in_ci;
          max_d   = in_max_iter;
          zr_d    = '0;
          zi_d    = '0;
          cnt_d   = '0;
          state_d = ST_ITER;
        end
      end

      ST_ITER: begin
        // Escape wins over every other exit; z keeps the escaping value.
        if (step_size) begin
          res_iter_d = cnt_q;
          res_esc_d  = 1'b1;
          state_d    = ST_DONE;
        end else if (fixed_pt) begin
          res_iter_d = max_q;
          res_esc_d  = 1'b0;
          state_d    = ST_DONE;
        end else if (cnt_q == max_q) begin
          // Checked before the increment, so the counter cannot wrap even
          // at the largest limit.
          res_iter_d = cnt_q;
          res_esc_d  = 1'b0;
          state_d    = ST_DONE;
        end else begin
          zr_d  = step_zr_next;
          zi_d  = step_zi_next;
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        if (result_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cr_q       <= '0;
      ci_q       <= '0;
      zr_q       <= '0;
      zi_q       <= '0;
      cnt_q      <= '0;
      max_q      <= '0;
      res_iter_q <= '0;
      res_esc_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples the values
      // from before this edge, independent of statement order.
      state_q    <= state_d;
      cr_q       <= cr_d;
      ci_q       <= ci_d;
      zr_q       <= zr_d;
      zi_q       <= zi_d;
      cnt_q      <= cnt_d;
      max_q      <= max_d;
      res_iter_q <= res_iter_d;
      res_esc_q  <= res_esc_d;
    end
  end

  assign start_ready    = (state_q == ST_IDLE);
  assign result_valid   = (state_q == ST_DONE);
  assign busy           = (state_q == ST_ITER) || (state_q == ST_DONE);
  assign result_iter    = res_iter_q;
  assign result_escaped = res_esc_q;

  assign step_cr = cr_q;
  assign step_ci = ci_q;
  assign step_zr = zr_q;
  assign step_zi = zi_q;

endmodule : mandelbrot_iter_ctrl
